ssi_slave_emu: RTL and testbench
================================

SSI_SLAVE_EMU -- requirements
Module: ssi_slave_emu

Interface
REQ-001 Parameter DATA_BITS, default 25, position word length in bits (legal range 8..32).
REQ-002 Parameter TM_CYCLES, default 2000, monoflop time tm in clk cycles (20 us at 100 MHz).
REQ-003 Parameter GRAY_EN, default 1; 1 = Gray-coded output, 0 = binary output.
REQ-004 Port clk, input, 1 bit: 100 MHz system clock; the block has one clock and all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-006 Port ssi_clk_in, input, 1 bit: SSI clock from an external master; asynchronous to clk; idle high.
REQ-007 Port pos_in, input, 32 bits: binary position, bits [DATA_BITS-1:0] used.
REQ-008 Port ssi_data_out, output, 1 bit: SSI data line; idle high.
REQ-009 Port busy, output, 1 bit: high while not IDLE.
REQ-010 Port frame_done, output, 1 bit: one-cycle pulse on MONO->IDLE.
REQ-011 Port err_timeout, output, 1 bit: one-cycle pulse on SHIFT abort.

Function
REQ-012 ssi_clk_in SHALL pass through a 2-FF synchronizer plus one edge-detect register; rise/fall strobes are single-cycle, 3 clk after the pin edge.
REQ-013 FSM states: IDLE, SHIFT, MONO.
REQ-014 IDLE, fall strobe: latch word = GRAY_EN ? (p ^ (p>>1)) : p, with p = pos_in[DATA_BITS-1:0]; clear bit_cnt; go to SHIFT; ssi_data_out stays 1.
REQ-015 SHIFT, rise strobe with bit_cnt < DATA_BITS: ssi_data_out <= word[DATA_BITS-1-bit_cnt] (MSB first); bit_cnt++.
REQ-016 SHIFT, rise strobe with bit_cnt == DATA_BITS: ssi_data_out <= 0; clear tm_cnt; go to MONO. A frame is DATA_BITS+1 clock pulses.
REQ-017 SHIFT, fall strobes: no data change.
REQ-018 SHIFT, no strobe for TM_CYCLES consecutive cycles:
  - pulse err_timeout;
  - ssi_data_out <= 1;
  - go to IDLE;
  - do not pulse frame_done.
REQ-019 MONO: ssi_data_out held 0; tm_cnt increments each cycle the synchronized clock is high.
REQ-020 MONO, tm_cnt reaches TM_CYCLES-1: ssi_data_out <= 1; pulse frame_done; go to IDLE.
REQ-021 MONO, fall strobe before timeout (repeat read):
  - re-send the same latched word, with no new pos_in sample;
  - clear bit_cnt and tm_cnt;
  - go to SHIFT.
REQ-022 Simultaneous tm_cnt expiry and fall strobe in MONO: the fall strobe wins (repeat read, no frame_done).
REQ-023 Widths:
  - bit_cnt: $clog2(DATA_BITS+1) bits, never wraps;
  - tm_cnt: $clog2(TM_CYCLES) bits, saturates;
  - pos_in bits above DATA_BITS-1 are ignored.
REQ-024 pos_in changes while not in IDLE SHALL NOT alter the transmitted word.

Reset
REQ-025 On rst asserted, immediately:
  - state = IDLE;
  - ssi_data_out = 1, busy = 0, frame_done = 0, err_timeout = 0;
  - counters = 0, word = 0;
  - synchronizer and edge registers = 1 (idle high).
REQ-026 Reset mid-frame SHALL abort with no pulses; after release, the first valid frame needs a fresh fall strobe.

Structure
REQ-027 The shared package ssi_pkg SHALL hold the state enum and the default DATA_BITS and TM_CYCLES constants.
REQ-028 The synchronizer and edge detector SHALL be one sub-module, ssi_edge_sync, with ports clk, rst, async_in, rise, fall, level.

Verification
REQ-029 Basic frame: DATA_BITS=13, TM_CYCLES=200, GRAY_EN=1, pos_in=0x0ABC, 14 pulses of a 1 MHz clock -> bits 0111111100010 (Gray 0x0FE2) on successive rises, then 0; after 200 high cycles, data goes 1 and frame_done pulses once.
REQ-030 Binary frame: GRAY_EN=0, same stimulus -> bits 0101010111100.
REQ-031 Repeat read: fall edge 50 cycles into MONO, pos_in changed to 0x1234 -> 0x0FE2 re-sent; no frame_done between the two frames.
REQ-032 Timeout: master stops after 5 bits, clock held high for 200 cycles -> err_timeout pulses once, data returns to 1, busy falls.
REQ-033 Reset after bit 7 -> data=1 and busy=0 with no clk edge needed; the next full frame is correct.
REQ-034 Expiry collision: fall edge arrives on the tm_cnt==199 cycle -> repeat frame starts and frame_done stays 0.

Source files
------------

// File: rtl/ssi_pkg.sv
// Shared definitions for the SSI slave emulator: FSM state encoding and
// default frame geometry.
package ssi_pkg;

    localparam int SSI_DATA_BITS = 25;
    localparam int SSI_TM_CYCLES = 2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MONO  = 2'd2
    } ssi_state_e;

endpackage

// File: rtl/ssi_edge_sync.sv
// Two-flop synchronizer for the external SSI clock plus an edge-detect
// register; everything resets to the idle-high level.
module ssi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ssi_slave_emu.sv
// SSI absolute-encoder slave: latches a position word on the first falling
// clock edge, shifts it out MSB first on rising edges, then holds the monoflop.
module ssi_slave_emu
    import ssi_pkg::*;
#(
    parameter int DATA_BITS = SSI_DATA_BITS,
    parameter int TM_CYCLES = SSI_TM_CYCLES,
    parameter int GRAY_EN   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ssi_clk_in,
    input  logic [31:0] pos_in,
    output logic        ssi_data_out,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TM_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);
    localparam logic [TW-1:0] TM_LAST  = TW'(TM_CYCLES - 1);

    ssi_state_e           state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        tm_cnt_q, tm_cnt_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 clk_rise;
    logic                 clk_fall;
    logic                 clk_level;
    logic [DATA_BITS-1:0] pos_bits;
    logic [DATA_BITS-1:0] new_word;
    logic [DATA_BITS-1:0] word_shifted;
    logic                 unused_pos_hi;

    ssi_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ssi_clk_in),
        .rise     (clk_rise),
        .fall     (clk_fall),
        .level    (clk_level)
    );

    assign pos_bits      = pos_in[DATA_BITS-1:0];
    assign new_word      = (GRAY_EN != 0) ? (pos_bits ^ (pos_bits >> 1)) : pos_bits;
    assign word_shifted  = word_q << bit_cnt_q;
    assign unused_pos_hi = ^pos_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tm_cnt_q  <= '0;
            word_q    <= '0;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tm_cnt_q  <= tm_cnt_d;
            word_q    <= word_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // In SHIFT, tm_cnt is the watchdog for a stalled master; in MONO it is
    // the monoflop timer and only advances while the clock line is high.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tm_cnt_d  = tm_cnt_q;
        word_d    = word_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clk_fall) begin
                    word_d    = new_word;
                    bit_cnt_d = '0;
                    tm_cnt_d  = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_rise) begin
                    tm_cnt_d = '0;
                    if (bit_cnt_q < BIT_LAST) begin
                        data_d    = word_shifted[DATA_BITS-1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        data_d  = 1'b0;
                        state_d = ST_MONO;
                    end
                end else if (clk_fall) begin
                    tm_cnt_d = '0;
                end else if (tm_cnt_q == TM_LAST) begin
                    err_d   = 1'b1;
                    data_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tm_cnt_d = tm_cnt_q + 1'b1;
                end
            end
            ST_MONO: begin
                // A falling edge outranks monoflop expiry: it is a repeat read.
                if (clk_fall) begin
                    bit_cnt_d = '0;
                    tm_cnt_d  = '0;
                    state_d   = ST_SHIFT;
                end else if (tm_cnt_q == TM_LAST) begin
                    data_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (clk_level) begin
                    tm_cnt_d = tm_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ssi_data_out = data_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = done_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_ssi_slave_emu.sv
// Scoreboard bench for ssi_slave_emu: a Gray and a binary instance share one
// SSI master; each rising SSI edge pops one expected data bit per instance.
module tb_ssi_slave_emu;

    localparam int DB   = 13;
    localparam int TM   = 200;
    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ssi_clk = 1'b1;
    logic [31:0] pos = 32'd0;

    logic data_g, busy_g, fd_g, err_g;
    logic data_b, busy_b, fd_b, err_b;

    int checks = 0;
    int errors = 0;
    int fd_cnt_g = 0, fd_cnt_b = 0, err_cnt_g = 0, err_cnt_b = 0;
    int fd0, err0;

    logic [0:0] exp_g_q[$];
    logic [0:0] exp_b_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d)", checks);
        $fatal(1);
    end

    ssi_slave_emu #(.DATA_BITS(DB), .TM_CYCLES(TM), .GRAY_EN(1)) dut_g (
        .clk(clk), .rst(rst), .ssi_clk_in(ssi_clk), .pos_in(pos),
        .ssi_data_out(data_g), .busy(busy_g), .frame_done(fd_g), .err_timeout(err_g)
    );

    ssi_slave_emu #(.DATA_BITS(DB), .TM_CYCLES(TM), .GRAY_EN(0)) dut_b (
        .clk(clk), .rst(rst), .ssi_clk_in(ssi_clk), .pos_in(pos),
        .ssi_data_out(data_b), .busy(busy_b), .frame_done(fd_b), .err_timeout(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- pulse counters ----------------
    always @(negedge clk) begin
        if (fd_g)  fd_cnt_g++;
        if (fd_b)  fd_cnt_b++;
        if (err_g) err_cnt_g++;
        if (err_b) err_cnt_b++;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge ssi_clk);
            repeat (6) @(posedge clk);
            @(negedge clk);
            if (exp_g_q.size() == 0 || exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: data_g=%0b data_b=%0b with no expectation queued", data_g, data_b);
            end else begin
                check("bit_gray", 32'(data_g), 32'(exp_g_q.pop_front()));
                check("bit_bin", 32'(data_b), 32'(exp_b_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic pulse(input int hi);
        ssi_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ssi_clk = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    // Pulses first..last-1; pulse i carries bit i (MSB first), pulse DB is the trailing 0.
    task automatic send_bits(input logic [DB-1:0] wg, input logic [DB-1:0] wb,
                             input int first, input int last, input int last_hi);
        for (int i = first; i < last; i++) begin
            if (i < DB) begin
                exp_g_q.push_back(wg[DB-1-i]);
                exp_b_q.push_back(wb[DB-1-i]);
            end else begin
                exp_g_q.push_back(1'b0);
                exp_b_q.push_back(1'b0);
            end
            pulse((i == last - 1) ? last_hi : HALF);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_g_q.size() != 0 || exp_b_q.size() != 0); i++)
            @(negedge clk);
    endtask

    task automatic wait_fd(input int base, input int limit);
        for (int i = 0; i < limit && fd_cnt_g == base; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_err(input int base, input int limit);
        for (int i = 0; i < limit && err_cnt_g == base; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data_g"}, 32'(data_g), 32'd1);
        check({tag, "_data_b"}, 32'(data_b), 32'd1);
        check({tag, "_busy_g"}, 32'(busy_g), 32'd0);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_fd_g", 32'(fd_g), 32'd0);
        check("reset_err_g", 32'(err_g), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic frame; pos_in disturbed mid-frame must not matter.
        fd0 = fd_cnt_g;
        pos = 32'h0000_0ABC;
        send_bits(13'h0FE2, 13'h0ABC, 0, 6, HALF);
        pos = 32'h0000_1FFF;
        send_bits(13'h0FE2, 13'h0ABC, 6, 14, HALF);
        drain();
        check("mono_hold_data_g", 32'(data_g), 32'd0);
        check("mono_busy_g", 32'(busy_g), 32'd1);
        check("mono_no_early_done", 32'(fd_cnt_g - fd0), 32'd0);
        wait_fd(fd0, 300);
        check("basic_fd_g", 32'(fd_cnt_g - fd0), 32'd1);
        check("basic_fd_b", 32'(fd_cnt_b - fd0), 32'd1);
        check_idle("basic_end");

        // Repeat read ~50 cycles into MONO with a new pos_in.
        fd0 = fd_cnt_g;
        err0 = err_cnt_g;
        pos = 32'h0000_0ABC;
        send_bits(13'h0FE2, 13'h0ABC, 0, 14, HALF);
        repeat (3) @(negedge clk);
        pos = 32'h0000_1234;
        send_bits(13'h0FE2, 13'h0ABC, 0, 14, HALF);
        drain();
        check("repeat_no_done_between", 32'(fd_cnt_g - fd0), 32'd0);
        wait_fd(fd0, 300);
        check("repeat_fd_g", 32'(fd_cnt_g - fd0), 32'd1);
        check("repeat_err_g", 32'(err_cnt_g - err0), 32'd0);
        check_idle("repeat_end");

        // Master stalls after 5 bits with the clock high.
        fd0 = fd_cnt_g;
        err0 = err_cnt_g;
        pos = 32'h0000_0ABC;
        send_bits(13'h0FE2, 13'h0ABC, 0, 5, HALF);
        repeat (100) @(negedge clk);
        check("stall_busy_g", 32'(busy_g), 32'd1);
        check("stall_no_early_err", 32'(err_cnt_g - err0), 32'd0);
        wait_err(err0, 300);
        check("timeout_err_g", 32'(err_cnt_g - err0), 32'd1);
        check("timeout_err_b", 32'(err_cnt_b - err0), 32'd1);
        check("timeout_no_done", 32'(fd_cnt_g - fd0), 32'd0);
        check_idle("timeout_end");

        // Asynchronous reset after bit 7, checked before any clk edge.
        fd0 = fd_cnt_g;
        err0 = err_cnt_g;
        send_bits(13'h0FE2, 13'h0ABC, 0, 7, HALF);
        drain();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_no_pulses", 32'((fd_cnt_g - fd0) + (err_cnt_g - err0)), 32'd0);
        pos = 32'hABCD_F234;
        send_bits(13'h1B2E, 13'h1234, 0, 14, HALF);
        drain();
        wait_fd(fd0, 300);
        check("after_reset_fd_g", 32'(fd_cnt_g - fd0), 32'd1);
        check_idle("after_reset_end");

        // Fall edge lands on the tm_cnt == TM-1 cycle: repeat read wins.
        fd0 = fd_cnt_g;
        err0 = err_cnt_g;
        pos = 32'h0000_0ABC;
        send_bits(13'h0FE2, 13'h0ABC, 0, 14, TM);
        pos = 32'h0000_1234;
        send_bits(13'h0FE2, 13'h0ABC, 0, 14, HALF);
        drain();
        check("collision_no_done", 32'(fd_cnt_g - fd0), 32'd0);
        wait_fd(fd0, 300);
        check("collision_fd_g", 32'(fd_cnt_g - fd0), 32'd1);
        check("collision_fd_b", 32'(fd_cnt_b - fd0), 32'd1);
        check("collision_err", 32'(err_cnt_g - err0), 32'd0);
        check_idle("collision_end");

        check("queue_empty_g", 32'(exp_g_q.size()), 32'd0);
        check("queue_empty_b", 32'(exp_b_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
